stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NSHIFT, default 2: serial bits moved per ALU cycle.
REQ-002 SHALL have parameter REG_BITS, default 8: register width; a power of two and a multiple of NSHIFT.
REQ-003 SHALL have parameter MAX_STAGES, default 4: number of stage slots; SB = $clog2(MAX_STAGES), CB = $clog2(2*REG_BITS/NSHIFT).
REQ-004 SHALL have ports:
 clk  in  1  clock
 reset  in  1  synchronous, active-high
 inst_valid  in  1  instruction and all descriptor inputs valid; held stable until inst_done
 inst_done  out  1  one-cycle completion pulse
 skipped  out  1  coincident with inst_done; instruction was condition-skipped
 stage_mask  in  MAX_STAGES  bit i set = stage i executes
 stage_wide  in  MAX_STAGES  bit i set = stage i runs 2*REG_BITS bits, else REG_BITS
 stage_send  in  MAX_STAGES  bit i set = stage i issues a TX command
 stage_wait_rx  in  MAX_STAGES  bit i set = stage i consumes RX data
 need_imm16  in  1  instruction needs a 16-bit immediate
 imm16_loaded  in  1  immediate now available (pulse)
 load_imm16  out  1  request immediate fetch
 use_cc  in  1  instruction is conditional
 cc  in  4  condition code
 flags  in  4  {c,v,s,z}
 tx_command_valid  out  1  TX command request
 tx_command_started  in  1  TX accepted the command
 tx_data_next  in  1  TX consumes NSHIFT bits this cycle
 rx_data_valid  in  1  RX delivers NSHIFT bits this cycle
 stage  out  SB  current stage index
 advance  out  1  ALU enable this cycle
 step  out  CB  serial step index within the stage
 stage_last_step  out  1  advance on the final step of the stage

Function
REQ-005 SHALL be an FSM with states IDLE, IMM, CMD, RUN, DONE.
REQ-006 IDLE with inst_valid SHALL go to IMM if need_imm16 else evaluate the condition in the same cycle.
REQ-007 IMM SHALL hold load_imm16=1 until imm16_loaded, then evaluate the condition; load_imm16 SHALL be 0 in all other states.
REQ-008 Condition: cc[2:0] 0 always, 1 z, 2 s, 3 c, 4 c&!z, 5 v, 6 v&!z, 7 never; cc[3] inverts; when use_cc=0 the result SHALL be true.
REQ-009 A false condition, or stage_mask==0, SHALL go to DONE; skipped=1 only for the false-condition case.
REQ-010 A true condition with a nonzero mask SHALL enter the lowest set stage: CMD if its stage_send bit is set, else RUN.
REQ-011 CMD SHALL assert tx_command_valid until and including the tx_command_started cycle, then go to RUN; tx_command_valid SHALL be 0 outside CMD.
REQ-012 RUN: advance = !(send && !tx_data_next) && !(wait_rx && !rx_data_valid), using the current stage's send and wait_rx bits; advance SHALL be 0 outside RUN.
REQ-013 step SHALL increment on each advance, zero on stage entry, and count N = (wide ? 2*REG_BITS : REG_BITS)/NSHIFT steps.
REQ-014 stage_last_step SHALL be advance && step==N-1; on that cycle the FSM SHALL move to the next higher set stage (CMD or RUN per REQ-010) or, if none, to DONE.
REQ-015 DONE SHALL last one cycle with inst_done=1, then return to IDLE; the sequencer SHALL NOT start a new instruction in the DONE cycle.
REQ-016 stage SHALL hold the active stage index during CMD and RUN and be 0 otherwise.
REQ-017 inst_valid falling mid-instruction SHALL be ignored; the instruction completes.
REQ-018 Descriptor inputs SHALL be sampled combinationally; they are stable per REQ-004.

Reset
REQ-019 reset SHALL force IDLE on the next edge: stage=0, step=0, and all outputs 0, including mid-instruction; no inst_done for an aborted instruction.

Verification
REQ-020 Defaults; mask=0001, narrow, no send, no rx, use_cc=0 -> advance for 4 cycles, step 0..3, inst_done on the 5th cycle, skipped=0.
REQ-021 mask=0101, stage0 wide+send, stage2 narrow+wait_rx; tx_command_started after 3 cycles; tx_data_next every other cycle; rx_data_valid gapped -> tx_command_valid for 3 cycles, 8 gated stage-0 steps, stage jumps 0->2, 4 steps, then inst_done.
REQ-022 need_imm16=1, use_cc=1, cc=0001, z=0; imm16_loaded after 5 cycles -> load_imm16 high for 5 cycles, then inst_done with skipped=1, advance never high.
REQ-023 All 16 cc values against all 16 flag combinations -> execute/skip matches REQ-008.
REQ-024 reset asserted at step 2 of stage 1 -> next cycle IDLE with all outputs 0; a new instruction then runs from stage 0.
REQ-025 use_cc=1, cc=0111 (never) -> immediate inst_done with skipped=1; with cc=1111 -> executes.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: sequences a bit-serial ALU instruction through up to
// MAX_STAGES stage slots. An instruction optionally fetches a 16-bit
// immediate and optionally evaluates a condition code against the ALU flags.
// It then walks its enabled stages in ascending order. A stage may first
// issue a TX command, and it steps the ALU NSHIFT bits per advance, gated by
// TX/RX data availability.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inst_valid                  instruction + descriptors valid (held until inst_done)
//   inst_done, skipped          one-cycle completion pulse, condition-skip flag
//   stage_mask/wide/send/wait_rx  per-stage descriptor bits
//   need_imm16, imm16_loaded, load_imm16   immediate fetch handshake
//   use_cc, cc, flags           condition evaluation ({c,v,s,z})
//   tx_command_valid, tx_command_started   TX command handshake
//   tx_data_next, rx_data_valid serial data availability
//   stage, advance, step, stage_last_step  ALU control outputs
module stage_sequencer #(
  parameter int NSHIFT     = 2,
  parameter int REG_BITS   = 8,
  parameter int MAX_STAGES = 4,
  localparam int SB = $clog2(MAX_STAGES),
  localparam int CB = $clog2(2*REG_BITS/NSHIFT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_valid,
  output logic                  inst_done,
  output logic                  skipped,
  input  logic [MAX_STAGES-1:0] stage_mask,
  input  logic [MAX_STAGES-1:0] stage_wide,
  input  logic [MAX_STAGES-1:0] stage_send,
  input  logic [MAX_STAGES-1:0] stage_wait_rx,
  input  logic                  need_imm16,
  input  logic                  imm16_loaded,
  output logic                  load_imm16,
  input  logic                  use_cc,
  input  logic [3:0]            cc,
  input  logic [3:0]            flags,
  output logic                  tx_command_valid,
  input  logic                  tx_command_started,
  input  logic                  tx_data_next,
  input  logic                  rx_data_valid,
  output logic [SB-1:0]         stage,
  output logic                  advance,
  output logic [CB-1:0]         step,
  output logic                  stage_last_step
);

  localparam logic [CB-1:0] LAST_NARROW = CB'(REG_BITS/NSHIFT - 1);
  localparam logic [CB-1:0] LAST_WIDE   = CB'(2*REG_BITS/NSHIFT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMM,
    S_CMD,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SB-1:0]   stage_q, stage_d;
  logic [CB-1:0]   step_q, step_d;
  logic            skipped_q, skipped_d;

  logic            cond_raw, cond_ok;
  logic            first_found, next_found;
  logic [SB-1:0]   first_idx, next_idx;
  logic            cur_send, cur_rx, cur_wide;
  logic [CB-1:0]   last_step_idx;
  logic            launch;

  // Condition evaluation; flags = {c,v,s,z}, cc[3] inverts the sense.
  always_comb begin
    cond_raw = 1'b1;
    case (cc[2:0])
      3'd0:    cond_raw = 1'b1;
      3'd1:    cond_raw = flags[0];
      3'd2:    cond_raw = flags[1];
      3'd3:    cond_raw = flags[3];
      3'd4:    cond_raw = flags[3] & ~flags[0];
      3'd5:    cond_raw = flags[2];
      3'd6:    cond_raw = flags[2] & ~flags[0];
      default: cond_raw = 1'b0;
    endcase
    cond_ok = !use_cc || (cond_raw ^ cc[3]);
  end

  // Lowest enabled stage overall, and lowest enabled stage above the active one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (stage_mask[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = SB'(i);
      end
      if (stage_mask[i] && !next_found && (SB'(i) > stage_q)) begin
        next_found = 1'b1;
        next_idx   = SB'(i);
      end
    end
  end

  always_comb begin
    cur_send      = stage_send[stage_q];
    cur_rx        = stage_wait_rx[stage_q];
    cur_wide      = stage_wide[stage_q];
    last_step_idx = cur_wide ? LAST_WIDE : LAST_NARROW;
  end

  assign load_imm16       = (state_q == S_IMM);
  assign tx_command_valid = (state_q == S_CMD);
  assign advance          = (state_q == S_RUN) && !(cur_send && !tx_data_next)
                            && !(cur_rx && !rx_data_valid);
  assign stage_last_step  = advance && (step_q == last_step_idx);
  assign inst_done        = (state_q == S_DONE);
  assign skipped          = (state_q == S_DONE) && skipped_q;
  assign stage            = stage_q;
  assign step             = step_q;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    step_d    = step_q;
    skipped_d = skipped_q;
    launch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          if (need_imm16) state_d = S_IMM;
          else            launch  = 1'b1;
        end
      end
      S_IMM: begin
        if (imm16_loaded) launch = 1'b1;
      end
      S_CMD: begin
        if (tx_command_started) state_d = S_RUN;
      end
      S_RUN: begin
        if (advance) begin
          step_d = step_q + 1'b1;
          if (stage_last_step) begin
            step_d = '0;
            if (next_found) begin
              stage_d = next_idx;
              state_d = stage_send[next_idx] ? S_CMD : S_RUN;
            end else begin
              stage_d   = '0;
              skipped_d = 1'b0;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        skipped_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Condition evaluation is shared by the IDLE and IMM exits.
    if (launch) begin
      step_d = '0;
      if (!cond_ok) begin
        stage_d   = '0;
        skipped_d = 1'b1;
        state_d   = S_DONE;
      end else if (!first_found) begin
        stage_d   = '0;
        skipped_d = 1'b0;
        state_d   = S_DONE;
      end else begin
        stage_d   = first_idx;
        skipped_d = 1'b0;
        state_d   = stage_send[first_idx] ? S_CMD : S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      step_q    <= '0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      step_q    <= step_d;
      skipped_q <= skipped_d;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed self-checking bench for stage_sequencer with
// default parameters (NSHIFT=2, REG_BITS=8, MAX_STAGES=4).
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       inst_valid;
  logic       inst_done;
  logic       skipped;
  logic [3:0] stage_mask, stage_wide, stage_send, stage_wait_rx;
  logic       need_imm16, imm16_loaded, load_imm16;
  logic       use_cc;
  logic [3:0] cc, flags;
  logic       tx_command_valid, tx_command_started, tx_data_next, rx_data_valid;
  logic [1:0] stage;
  logic       advance;
  logic [2:0] step;
  logic       stage_last_step;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stage_sequencer #(
    .NSHIFT(2),
    .REG_BITS(8),
    .MAX_STAGES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_valid(inst_valid),
    .inst_done(inst_done),
    .skipped(skipped),
    .stage_mask(stage_mask),
    .stage_wide(stage_wide),
    .stage_send(stage_send),
    .stage_wait_rx(stage_wait_rx),
    .need_imm16(need_imm16),
    .imm16_loaded(imm16_loaded),
    .load_imm16(load_imm16),
    .use_cc(use_cc),
    .cc(cc),
    .flags(flags),
    .tx_command_valid(tx_command_valid),
    .tx_command_started(tx_command_started),
    .tx_data_next(tx_data_next),
    .rx_data_valid(rx_data_valid),
    .stage(stage),
    .advance(advance),
    .step(step),
    .stage_last_step(stage_last_step)
  );

  function automatic logic exp_cond(input logic [3:0] cc_v, input logic [3:0] f);
    logic c, v, s, z, r;
    {c, v, s, z} = f;
    case (cc_v[2:0])
      3'd0:    r = 1'b1;
      3'd1:    r = z;
      3'd2:    r = s;
      3'd3:    r = c;
      3'd4:    r = c & ~z;
      3'd5:    r = v;
      3'd6:    r = v & ~z;
      default: r = 1'b0;
    endcase
    return r ^ cc_v[3];
  endfunction

  task automatic idle_inputs();
    inst_valid = 1'b0; stage_mask = '0; stage_wide = '0; stage_send = '0;
    stage_wait_rx = '0; need_imm16 = 1'b0; imm16_loaded = 1'b0; use_cc = 1'b0;
    cc = '0; flags = '0; tx_command_started = 1'b0; tx_data_next = 1'b0;
    rx_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b1;
    idle_inputs();
    inst_valid = 1'b1;
    stage_mask = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    got = {inst_done, skipped, load_imm16, tx_command_valid, advance,
           stage_last_step, stage, step, 2'b00};
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    @(negedge clk);
    reset = 1'b0;
    inst_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int         exp_step [7] = '{0, 0, 1, 2, 3, 0, 0};
    logic [6:0] adv_m  = 7'b0011110;
    logic [6:0] last_m = 7'b0010000;
    logic [6:0] done_m = 7'b0100000;
    logic [8:0] got, exp;
    idle_inputs();
    stage_mask = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      inst_valid = (c < 6);
      #1;
      got = {advance, stage_last_step, inst_done, skipped, stage, step};
      exp = {adv_m[c], last_m[c], done_m[c], 1'b0, 2'd0, 3'(exp_step[c])};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_two_stage();
    int exp_step [28] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7,
                          0, 0, 1, 2, 2, 2, 3, 0, 0};
    logic [27:0] txv_m  = 28'h000000E;
    logic [27:0] adv_m  = 28'h3355550;
    logic [27:0] last_m = 28'h2040000;
    logic [27:0] done_m = 28'h4000000;
    logic [27:0] rx_m   = 28'h33000A0;
    logic [9:0]  got, exp;
    logic [1:0]  exp_stage;
    idle_inputs();
    stage_mask    = 4'b0101;
    stage_wide    = 4'b0001;
    stage_send    = 4'b0001;
    stage_wait_rx = 4'b0100;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      inst_valid         = (c < 27);
      tx_command_started = (c == 3);
      tx_data_next       = (c >= 4) && (c % 2 == 0);
      rx_data_valid      = rx_m[c];
      #1;
      exp_stage = (c >= 19 && c <= 25) ? 2'd2 : 2'd0;
      got = {tx_command_valid, advance, stage_last_step, inst_done, skipped, stage, step};
      exp = {txv_m[c], adv_m[c], last_m[c], done_m[c], 1'b0, exp_stage, 3'(exp_step[c])};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL two_stage c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_imm_skip();
    logic [7:0] load_m = 8'h3E;
    logic [7:0] done_m = 8'h40;
    logic [3:0] got, exp;
    idle_inputs();
    stage_mask = 4'b0001;
    need_imm16 = 1'b1;
    use_cc     = 1'b1;
    cc         = 4'b0001;
    flags      = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      inst_valid   = (c < 7);
      imm16_loaded = (c == 5);
      #1;
      got = {load_imm16, advance, inst_done, skipped};
      exp = {load_m[c], 1'b0, done_m[c], done_m[c]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL imm_skip c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_cc_table();
    logic       run, seen;
    logic [2:0] got, exp;
    for (int ci = 0; ci < 16; ci++) begin
      for (int fi = 0; fi < 16; fi++) begin
        @(negedge clk);
        idle_inputs();
        stage_mask = 4'b0001;
        use_cc     = 1'b1;
        cc         = 4'(ci);
        flags      = 4'(fi);
        inst_valid = 1'b1;
        run = exp_cond(4'(ci), 4'(fi));
        @(negedge clk);
        #1;
        got = {advance, inst_done, skipped};
        exp = run ? 3'b100 : 3'b011;
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL cc_table cc=%h flags=%h got=%b exp=%b", ci, fi, got, exp);
        end
        seen = inst_done;
        for (int k = 0; k < 8 && !seen; k++) begin
          @(negedge clk);
          #1;
          seen = inst_done;
        end
        tests++;
        if (!seen) begin
          fails++;
          $display("FAIL cc_table_done cc=%h flags=%h got=timeout exp=inst_done", ci, fi);
        end
        inst_valid = 1'b0;
      end
    end
    idle_inputs();
  endtask

  task automatic test_never_and_empty();
    logic [2:0] got;
    logic       seen;
    // cc=0111 never executes
    @(negedge clk);
    idle_inputs();
    stage_mask = 4'b0001; use_cc = 1'b1; cc = 4'b0111; inst_valid = 1'b1;
    @(negedge clk);
    #1;
    got = {inst_done, skipped, advance};
    tests++;
    if (got !== 3'b110) begin
      fails++;
      $display("FAIL never_skip got=%b exp=110", got);
    end
    inst_valid = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (inst_done !== 1'b0) begin
      fails++;
      $display("FAIL done_one_cycle got=%b exp=0", inst_done);
    end
    // cc=1111 always executes
    @(negedge clk);
    cc = 4'b1111; inst_valid = 1'b1;
    @(negedge clk);
    #1;
    got = {inst_done, skipped, advance};
    tests++;
    if (got !== 3'b001) begin
      fails++;
      $display("FAIL inv_never_exec got=%b exp=001", got);
    end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = inst_done;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL inv_never_done got=timeout exp=inst_done");
    end
    inst_valid = 1'b0;
    // empty mask completes without skip
    @(negedge clk);
    idle_inputs();
    inst_valid = 1'b1;
    @(negedge clk);
    #1;
    got = {inst_done, skipped, advance};
    tests++;
    if (got !== 3'b100) begin
      fails++;
      $display("FAIL empty_mask got=%b exp=100", got);
    end
    inst_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [5:0]  got;
    logic [12:0] all;
    logic        seen;
    @(negedge clk);
    idle_inputs();
    stage_mask = 4'b0011;
    inst_valid = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    got = {stage, step, advance};
    tests++;
    if (got !== {2'd1, 3'd2, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_pre got=%b exp=010101", got);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    inst_valid = 1'b0;
    #1;
    all = {inst_done, skipped, load_imm16, tx_command_valid, advance,
           stage_last_step, stage, step, 2'b00};
    tests++;
    if (all !== '0) begin
      fails++;
      $display("FAIL reset_mid_idle got=%h exp=0", all);
    end
    @(negedge clk);
    inst_valid = 1'b1;
    @(negedge clk);
    #1;
    got = {stage, step, advance};
    tests++;
    if (got !== {2'd0, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_restart got=%b exp=000001", got);
    end
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = inst_done;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL reset_mid_done got=timeout exp=inst_done");
    end
    inst_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_two_stage();
    test_imm_skip();
    test_cc_table();
    test_never_and_empty();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
